// File: rtl/top_score_board.sv
// Ranked leaderboard of the N best scores with a rank-select
// seven-segment read-out. W must equal 4*DIGITS (packed BCD).
// Scores are compared as raw unsigned vectors. For packed BCD this
// gives the same order as decimal.

module BCD_decoder (
    input  logic [3:0] bcd,
    input  logic       dp,
    output logic [7:0] seg
);
    logic [6:0] segs;

    // Active-high segments {g,f,e,d,c,b,a}; non-BCD nibbles are blanked
    always_comb begin
        segs = 7'h00;
        case (bcd)
            4'd0: segs = 7'h3F;
            4'd1: segs = 7'h06;
            4'd2: segs = 7'h5B;
            4'd3: segs = 7'h4F;
            4'd4: segs = 7'h66;
            4'd5: segs = 7'h6D;
            4'd6: segs = 7'h7D;
            4'd7: segs = 7'h07;
            4'd8: segs = 7'h7F;
            4'd9: segs = 7'h6F;
            default: segs = 7'h00;
        endcase
    end

    assign seg = {dp, segs};
endmodule

module top_score_board #(
    parameter int W           = 16,
    parameter int DIGITS      = 4,
    parameter int N           = 4,
    parameter int LOW_IS_BEST = 1,
    parameter int RW          = $clog2(N + 1)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [W-1:0]          score,
    input  logic                  score_valid,
    input  logic                  clear,
    input  logic [RW-1:0]         rank_sel,
    output logic [8*DIGITS-1:0]   hex,
    output logic [W-1:0]          sel_score,
    output logic                  sel_valid,
    output logic [RW-1:0]         entries,
    output logic                  ins_taken,
    output logic [RW-1:0]         ins_rank,
    output logic                  new_best
);
    logic [W-1:0]  val_q [N];
    logic [W-1:0]  val_d [N];
    logic [N-1:0]  vld_q, vld_d;
    logic [RW-1:0] entries_q, entries_d;
    logic          ins_taken_q, ins_taken_d;
    logic [RW-1:0] ins_rank_q, ins_rank_d;
    logic          new_best_q, new_best_d;
    logic          score_valid_q, score_valid_d;

    logic          ev;
    logic          ins_found;
    logic [RW-1:0] ins_pos;

    // A held-high strobe counts only once, on its rising edge.
    assign ev = score_valid & ~score_valid_q;

    function automatic logic better(input logic [W-1:0] a, input logic [W-1:0] b);
        if (LOW_IS_BEST != 0) return a < b;
        else                  return a > b;
    endfunction

    // The insertion point is the first empty slot, or the first entry
    // that the new score strictly beats. Because the test is strict,
    // an equal score lands after the entry that is already there.
    always_comb begin
        ins_found = 1'b0;
        ins_pos   = '0;
        for (int k = 0; k < N; k++) begin
            if (!ins_found && (!vld_q[k] || better(score, val_q[k]))) begin
                ins_found = 1'b1;
                ins_pos   = RW'(k);
            end
        end
    end

    // Next-state: clear wins, else single-edge shift-and-insert
    always_comb begin
        val_d         = val_q;
        vld_d         = vld_q;
        entries_d     = entries_q;
        ins_taken_d   = 1'b0;
        ins_rank_d    = ins_rank_q;
        new_best_d    = 1'b0;
        score_valid_d = score_valid;

        if (clear) begin
            vld_d      = '0;
            entries_d  = '0;
            ins_rank_d = '0;
        end else if (ev && ins_found) begin
            for (int k = 1; k < N; k++) begin
                if (k > int'(ins_pos)) begin
                    val_d[k] = val_q[k-1];
                    vld_d[k] = vld_q[k-1];
                end
            end
            for (int k = 0; k < N; k++) begin
                if (k == int'(ins_pos)) begin
                    val_d[k] = score;
                    vld_d[k] = 1'b1;
                end
            end
            entries_d   = (entries_q == RW'(N)) ? entries_q : entries_q + RW'(1);
            ins_taken_d = 1'b1;
            ins_rank_d  = ins_pos;
            new_best_d  = (ins_pos == '0);
        end
    end

    // State registers; asynchronous reset wipes the whole board at once
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < N; k++) val_q[k] <= '0;
            vld_q         <= '0;
            entries_q     <= '0;
            ins_taken_q   <= 1'b0;
            ins_rank_q    <= '0;
            new_best_q    <= 1'b0;
            score_valid_q <= 1'b0;
        end else begin
            val_q         <= val_d;
            vld_q         <= vld_d;
            entries_q     <= entries_d;
            ins_taken_q   <= ins_taken_d;
            ins_rank_q    <= ins_rank_d;
            new_best_q    <= new_best_d;
            score_valid_q <= score_valid_d;
        end
    end

    // Rank-select read-out; an out-of-range rank matches no entry and reads as empty
    always_comb begin
        sel_valid = 1'b0;
        sel_score = '0;
        for (int k = 0; k < N; k++) begin
            if (rank_sel == RW'(k)) begin
                sel_valid = vld_q[k];
                sel_score = vld_q[k] ? val_q[k] : '0;
            end
        end
    end

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        BCD_decoder u_dec (
            .bcd (sel_score[4*i +: 4]),
            .dp  (i == DIGITS - 1),
            .seg (hex[8*i +: 8])
        );
    end

    assign entries   = entries_q;
    assign ins_taken = ins_taken_q;
    assign ins_rank  = ins_rank_q;
    assign new_best  = new_best_q;
endmodule

// File: tb/tb_top_score_board.sv
// Bench for top_score_board. It uses two builds: a low-is-best board
// (dut) and a high-is-best board (dut_b).

module tb_top_score_board;
    localparam int W  = 16;
    localparam int N  = 4;
    localparam int RW = 3;

    localparam logic [31:0] HEX_ZERO = 32'hBF3F3F3F;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic [W-1:0]  score = '0;
    logic          score_valid = 1'b0;
    logic          clear = 1'b0;
    logic [RW-1:0] rank_sel = '0;
    logic [31:0]   hex;
    logic [W-1:0]  sel_score;
    logic          sel_valid;
    logic [RW-1:0] entries;
    logic          ins_taken;
    logic [RW-1:0] ins_rank;
    logic          new_best;

    logic [W-1:0]  score_b = '0;
    logic          score_valid_b = 1'b0;
    logic [RW-1:0] rank_sel_b = '0;
    logic [31:0]   hex_b;
    logic [W-1:0]  sel_score_b;
    logic          sel_valid_b;
    logic [RW-1:0] entries_b;
    logic          ins_taken_b;
    logic [RW-1:0] ins_rank_b;
    logic          new_best_b;

    top_score_board #(.W(16), .DIGITS(4), .N(4), .LOW_IS_BEST(1)) dut (
        .clk(clk), .reset_n(reset_n), .score(score), .score_valid(score_valid),
        .clear(clear), .rank_sel(rank_sel), .hex(hex), .sel_score(sel_score),
        .sel_valid(sel_valid), .entries(entries), .ins_taken(ins_taken),
        .ins_rank(ins_rank), .new_best(new_best)
    );

    top_score_board #(.W(16), .DIGITS(4), .N(4), .LOW_IS_BEST(0)) dut_b (
        .clk(clk), .reset_n(reset_n), .score(score_b), .score_valid(score_valid_b),
        .clear(1'b0), .rank_sel(rank_sel_b), .hex(hex_b), .sel_score(sel_score_b),
        .sel_valid(sel_valid_b), .entries(entries_b), .ins_taken(ins_taken_b),
        .ins_rank(ins_rank_b), .new_best(new_best_b)
    );

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;
    logic [RW-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Each accepted insert has a rank queued when it was driven; pop on the pulse
    always @(negedge clk) begin
        if (reset_n && ins_taken) begin
            if (exp_q.size() == 0) begin
                check("unexpected_ins_taken", 32'(ins_taken), 32'd0);
            end else begin
                check("sb_ins_rank", 32'(ins_rank), 32'(exp_q.pop_front()));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic strobe(input logic [W-1:0] s);
        @(negedge clk);
        score       = s;
        score_valid = 1'b1;
        @(negedge clk);
        score_valid = 1'b0;
    endtask

    task automatic strobe_b(input logic [W-1:0] s);
        @(negedge clk);
        score_b       = s;
        score_valid_b = 1'b1;
        @(negedge clk);
        score_valid_b = 1'b0;
    endtask

    task automatic check_board(input string tag, input logic [W-1:0] e [N], input int nv);
        for (int r = 0; r < N; r++) begin
            rank_sel = RW'(r);
            #1;
            check({tag, "_vld"}, 32'(sel_valid), 32'(r < nv));
            check({tag, "_val"}, 32'(sel_score), (r < nv) ? 32'(e[r]) : 32'd0);
        end
        rank_sel = '0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [W-1:0]  score;
        logic          taken;
        logic [RW-1:0] rank;
        logic          best;
        logic [RW-1:0] ent;
    } vec_t;

    vec_t vecs[6];

    task automatic run_vecs(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            if (vecs[i].taken) exp_q.push_back(vecs[i].rank);
            strobe(vecs[i].score);
            check($sformatf("v%0d_taken", i), 32'(ins_taken), 32'(vecs[i].taken));
            check($sformatf("v%0d_rank", i), 32'(ins_rank), 32'(vecs[i].rank));
            check($sformatf("v%0d_best", i), 32'(new_best), 32'(vecs[i].best));
            check($sformatf("v%0d_entries", i), 32'(entries), 32'(vecs[i].ent));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;

        vecs[0] = '{16'h0250, 1'b1, 3'd0, 1'b1, 3'd1};
        vecs[1] = '{16'h0120, 1'b1, 3'd0, 1'b1, 3'd2};
        vecs[2] = '{16'h0300, 1'b1, 3'd2, 1'b0, 3'd3};
        vecs[3] = '{16'h0120, 1'b1, 3'd1, 1'b0, 3'd4};
        vecs[4] = '{16'h0500, 1'b0, 3'd1, 1'b0, 3'd4};
        vecs[5] = '{16'h0100, 1'b1, 3'd0, 1'b1, 3'd4};

        // Reset state
        #1;
        check("rst_entries", 32'(entries), 32'd0);
        check("rst_taken", 32'(ins_taken), 32'd0);
        check("rst_sel_score", 32'(sel_score), 32'd0);
        check("rst_hex", hex, HEX_ZERO);
        @(negedge clk);
        reset_n = 1'b1;

        // Fill, tie handling
        run_vecs(0, 3);
        check_board("fill", '{16'h0120, 16'h0120, 16'h0250, 16'h0300}, 4);
        rank_sel = 3'd1;
        #1;
        check("hex_0120", hex, 32'hBF065B3F);
        rank_sel = 3'd0;

        // Reject when full, then new best evicts the last entry
        run_vecs(4, 5);
        check_board("evict", '{16'h0100, 16'h0120, 16'h0120, 16'h0250}, 4);
        rank_sel = 3'd4;
        #1;
        check("rsel_n_vld", 32'(sel_valid), 32'd0);
        check("rsel_n_val", 32'(sel_score), 32'd0);
        check("rsel_n_hex", hex, HEX_ZERO);
        rank_sel = 3'd7;
        #1;
        check("rsel_7_vld", 32'(sel_valid), 32'd0);
        rank_sel = 3'd0;

        // Clear, then held-high strobe inserts once
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("clear_entries", 32'(entries), 32'd0);
        check_board("clear", '{16'h0, 16'h0, 16'h0, 16'h0}, 0);
        @(negedge clk);
        score = 16'h0050;
        score_valid = 1'b1;
        exp_q.push_back(3'd0);
        pulses = 0;
        repeat (10) begin
            @(negedge clk);
            pulses += int'(ins_taken);
        end
        score_valid = 1'b0;
        check("hold_pulses", 32'(pulses), 32'd1);
        check("hold_entries", 32'(entries), 32'd1);

        // All-ones and all-zeros scores are ordinary values
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        exp_q.push_back(3'd0);
        strobe(16'hFFFF);
        rank_sel = 3'd0;
        #1;
        check("ffff_vld", 32'(sel_valid), 32'd1);
        check("ffff_val", 32'(sel_score), 32'h0000FFFF);
        check("ffff_hex", hex, 32'h80000000);
        exp_q.push_back(3'd0);
        strobe(16'h0000);
        check_board("zero", '{16'h0000, 16'hFFFF, 16'h0, 16'h0}, 2);

        // Clear beats a simultaneous rising strobe
        @(negedge clk);
        score = 16'h0010;
        score_valid = 1'b1;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        score_valid = 1'b0;
        check("clrev_entries", 32'(entries), 32'd0);
        check("clrev_taken", 32'(ins_taken), 32'd0);
        check("clrev_best", 32'(new_best), 32'd0);
        check_board("clrev", '{16'h0, 16'h0, 16'h0, 16'h0}, 0);

        // Asynchronous reset right after an insert edge
        exp_q.push_back(3'd0);
        strobe(16'h0250);
        exp_q.push_back(3'd0);
        strobe(16'h0120);
        @(negedge clk);
        score = 16'h0200;
        score_valid = 1'b1;
        @(posedge clk);
        #1;
        score_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        check("arst_entries", 32'(entries), 32'd0);
        check("arst_taken", 32'(ins_taken), 32'd0);
        check("arst_rank", 32'(ins_rank), 32'd0);
        check("arst_best", 32'(new_best), 32'd0);
        check("arst_vld", 32'(sel_valid), 32'd0);
        check("arst_hex", hex, HEX_ZERO);
        @(negedge clk);
        #1;
        reset_n = 1'b1;
        exp_q.push_back(3'd0);
        strobe(16'h0777);
        check("post_rst_entries", 32'(entries), 32'd1);

        // High-is-best build
        strobe_b(16'h0010);
        check("b0_rank", 32'(ins_rank_b), 32'd0);
        check("b0_best", 32'(new_best_b), 32'd1);
        strobe_b(16'h0900);
        check("b1_rank", 32'(ins_rank_b), 32'd0);
        check("b1_best", 32'(new_best_b), 32'd1);
        strobe_b(16'h0500);
        check("b2_rank", 32'(ins_rank_b), 32'd1);
        check("b2_best", 32'(new_best_b), 32'd0);
        check("b2_taken", 32'(ins_taken_b), 32'd1);
        check("b_entries", 32'(entries_b), 32'd3);
        for (int r = 0; r < N; r++) begin
            logic [W-1:0] eb [N];
            eb = '{16'h0900, 16'h0500, 16'h0010, 16'h0000};
            rank_sel_b = RW'(r);
            #1;
            check($sformatf("b_board%0d_vld", r), 32'(sel_valid_b), 32'(r < 3));
            check($sformatf("b_board%0d_val", r), 32'(sel_score_b), 32'(eb[r]));
        end
        rank_sel_b = 3'd4;
        #1;
        check("b_rsel_n_vld", 32'(sel_valid_b), 32'd0);
        check("b_rsel_n_val", 32'(sel_score_b), 32'd0);
        check("b_rsel_n_hex", hex_b, HEX_ZERO);

        // Every queued insert must have been seen
        @(negedge clk);
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
